// File: rtl/uart_pixel_loader.sv
// UART-to-frame-buffer loader: packs received bytes MSB-first into pixels and writes them to sequential addresses.
// Optional per-frame header hunting is enabled by defining UART_SYNC_HDR_EN.
module uart_pixel_loader #(
    parameter int          PIXEL_W      = 12,
    parameter int          IMAGE_WIDTH  = 800,
    parameter int          IMAGE_HEIGHT = 600,
    parameter int          ONE_SHOT     = 0,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          FCNT_W       = 8,
    localparam int         NPIX         = IMAGE_WIDTH * IMAGE_HEIGHT,
    localparam int         ADDR_W       = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_empty,
    output logic                rd_uart,
    input  logic                start,
    input  logic                resync,
    output logic                w_en,
    output logic [ADDR_W-1:0]   w_addr,
    output logic [PIXEL_W-1:0]  w_data,
    output logic                frame_done,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic                busy
);
    localparam int BYTES  = (PIXEL_W + 7) / 8;
    localparam int PACK_W = BYTES * 8;
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef UART_SYNC_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HUNT  = 3'd1;
    localparam logic [2:0] RECV  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [PACK_W-1:0] pack_reg;
    logic [PACK_W-1:0] pack_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [FCNT_W-1:0] fcnt_reg;

    logic resync_eff;
    logic pop;
    logic write;
    logic last_pix;
    logic last_byte;

    // Single-byte pixels have no older bytes to keep in the pack register.
    generate
        if (BYTES == 1) begin : g_pack_one
            assign pack_next = rx_data;
        end else begin : g_pack_multi
            assign pack_next = {pack_reg[PACK_W-9:0], rx_data};
        end
    endgenerate

    always_comb begin
        resync_eff = resync && !((state_reg == IDLE) && (ONE_SHOT != 0));
        pop        = !resync_eff && !rx_empty &&
                     ((state_reg == RECV) || (HDR_EN && (state_reg == HUNT)));
        write      = !resync_eff && (state_reg == WRITE);
        last_pix   = (addr_reg == ADDR_W'(NPIX - 1));
        last_byte  = (idx_reg == IDX_W'(BYTES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            pack_reg  <= '0;
            addr_reg  <= '0;
            fcnt_reg  <= '0;
        end else if (resync_eff) begin
            state_reg <= HUNT;
            idx_reg   <= '0;
            pack_reg  <= '0;
            addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if ((ONE_SHOT == 0) || start) begin
                        state_reg <= HUNT;
                    end
                end
                HUNT: begin
                    // Header bytes are consumed, never stored in the pack register.
                    if (!HDR_EN || (pop && (rx_data == SYNC_BYTE))) begin
                        state_reg <= RECV;
                    end
                end
                RECV: begin
                    if (pop) begin
                        pack_reg <= pack_next;
                        if (last_byte) begin
                            idx_reg   <= '0;
                            state_reg <= WRITE;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (last_pix) begin
                        addr_reg <= '0;
                        fcnt_reg <= fcnt_reg + 1'b1;
                        if (ONE_SHOT != 0) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= HDR_EN ? HUNT : RECV;
                        end
                    end else begin
                        addr_reg  <= addr_reg + 1'b1;
                        state_reg <= RECV;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_reg <= HUNT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rd_uart    = pop;
    assign w_en       = write;
    assign w_addr     = addr_reg;
    assign w_data     = pack_reg[PACK_W-1 -: PIXEL_W];
    assign frame_done = write && last_pix;
    assign frame_cnt  = fcnt_reg;
    assign busy       = (state_reg == HUNT) || (state_reg == RECV) || (state_reg == WRITE);

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Directed testbench for uart_pixel_loader: four instances (12-bit continuous, 12-bit one-shot, 24-bit, 4-bit).
// Header-mode checks run instead of the plain-stream tests when UART_SYNC_HDR_EN is defined.
module tb_uart_pixel_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0][7:0] rx_data;
    logic [3:0]      rx_empty;
    logic [3:0]      rd;
    logic [3:0]      start;
    logic [3:0]      resync;
    logic [3:0]      wen;
    logic [3:0]      fd;
    logic [3:0]      busy;
    logic [3:0][7:0] fcnt;

    logic [3:0]  waddr_a, waddr_b;
    logic [1:0]  waddr_c, waddr_d;
    logic [11:0] wdata_a, wdata_b;
    logic [23:0] wdata_c;
    logic [3:0]  wdata_d;
    logic [31:0] waddr_x [4];
    logic [31:0] wdata_x [4];

    int checks = 0;
    int errors = 0;

    uart_pixel_loader #(.PIXEL_W(12), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .ONE_SHOT(0)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data[0]), .rx_empty(rx_empty[0]), .rd_uart(rd[0]),
        .start(start[0]), .resync(resync[0]), .w_en(wen[0]), .w_addr(waddr_a), .w_data(wdata_a),
        .frame_done(fd[0]), .frame_cnt(fcnt[0]), .busy(busy[0]));

    uart_pixel_loader #(.PIXEL_W(12), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .ONE_SHOT(1)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data[1]), .rx_empty(rx_empty[1]), .rd_uart(rd[1]),
        .start(start[1]), .resync(resync[1]), .w_en(wen[1]), .w_addr(waddr_b), .w_data(wdata_b),
        .frame_done(fd[1]), .frame_cnt(fcnt[1]), .busy(busy[1]));

    uart_pixel_loader #(.PIXEL_W(24), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .ONE_SHOT(0)) dut_c (
        .clk(clk), .rst(rst), .rx_data(rx_data[2]), .rx_empty(rx_empty[2]), .rd_uart(rd[2]),
        .start(start[2]), .resync(resync[2]), .w_en(wen[2]), .w_addr(waddr_c), .w_data(wdata_c),
        .frame_done(fd[2]), .frame_cnt(fcnt[2]), .busy(busy[2]));

    uart_pixel_loader #(.PIXEL_W(4), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .ONE_SHOT(0)) dut_d (
        .clk(clk), .rst(rst), .rx_data(rx_data[3]), .rx_empty(rx_empty[3]), .rd_uart(rd[3]),
        .start(start[3]), .resync(resync[3]), .w_en(wen[3]), .w_addr(waddr_d), .w_data(wdata_d),
        .frame_done(fd[3]), .frame_cnt(fcnt[3]), .busy(busy[3]));

    always_comb begin
        waddr_x[0] = 32'(waddr_a);
        waddr_x[1] = 32'(waddr_b);
        waddr_x[2] = 32'(waddr_c);
        waddr_x[3] = 32'(waddr_d);
        wdata_x[0] = 32'(wdata_a);
        wdata_x[1] = 32'(wdata_b);
        wdata_x[2] = 32'(wdata_c);
        wdata_x[3] = 32'(wdata_d);
    end

    // Write/pop monitor: logs every write with its address, data, frame_done and latency from the last pop.
    int cyc = 0;
    int pops [4];
    int nwr [4];
    int nfd [4];
    int last_rd_cyc [4];
    int log_addr [4][64];
    int log_data [4][64];
    int log_fd [4][64];
    int log_lat [4][64];
    int log_cyc [4][64];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                if (nwr[i] < 64) begin
                    log_addr[i][nwr[i]] = int'(waddr_x[i]);
                    log_data[i][nwr[i]] = int'(wdata_x[i]);
                    log_fd[i][nwr[i]]   = int'(fd[i]);
                    log_lat[i][nwr[i]]  = cyc - last_rd_cyc[i];
                    log_cyc[i][nwr[i]]  = cyc;
                end
                nwr[i]++;
            end
            if (fd[i]) nfd[i]++;
            if (rd[i]) begin
                pops[i]++;
                last_rd_cyc[i] = cyc;
            end
        end
    end

    task automatic send_byte(input int i, input logic [7:0] b);
        int t;
        t = 0;
        rx_data[i]  = b;
        rx_empty[i] = 1'b0;
        #1;
        while (!rd[i] && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!rd[i]) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout dut%0d: byte %h not popped after %0d cycles, required a pop", i, b, t);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        rx_empty[i] = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_write(input string name, input int i, input int n, input int addr, input int data);
        checks++;
        if (nwr[i] <= n) begin
            errors++;
            $display("FAIL %s: write count %0d, required write #%0d", name, nwr[i], n);
        end else if (log_addr[i][n] !== addr || log_data[i][n] !== data) begin
            errors++;
            $display("FAIL %s: addr %0d data %h, required addr %0d data %h", name,
                     log_addr[i][n], log_data[i][n], addr, data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({wen[i], fd[i], busy[i], rd[i]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_flags dut%0d: {w_en,frame_done,busy,rd_uart}=%b, required 0000", i,
                         {wen[i], fd[i], busy[i], rd[i]});
            end
            checks++;
            if (waddr_x[i] !== 32'd0 || wdata_x[i] !== 32'd0 || fcnt[i] !== 8'd0) begin
                errors++;
                $display("FAIL reset_values dut%0d: addr %h data %h cnt %h, required all 0", i,
                         waddr_x[i], wdata_x[i], fcnt[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_reset_cont: busy %b, required 1", busy[0]);
        end
        checks++;
        if (busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_reset_oneshot: busy %b, required 0", busy[1]);
        end
    endtask

    task automatic test_first_pixel();
        int n0;
        n0 = nwr[0];
        send_byte(0, 8'hAB);
        send_byte(0, 8'hCD);
        settle();
        checks++;
        if (nwr[0] !== n0 + 1) begin
            errors++;
            $display("FAIL first_pixel_count: %0d writes, required 1", nwr[0] - n0);
        end
        check_write("first_pixel", 0, n0, 0, 32'hABC);
        checks++;
        if (log_lat[0][n0] !== 1 || log_fd[0][n0] !== 0) begin
            errors++;
            $display("FAIL first_pixel_timing: latency %0d frame_done %0d, required latency 1 frame_done 0",
                     log_lat[0][n0], log_fd[0][n0]);
        end
    endtask

    task automatic test_frame();
        int n0, f0;
        logic [7:0] b0;
        n0 = nwr[0];
        f0 = nfd[0];
        for (int p = 1; p <= 16; p++) begin
            b0 = 8'h10 + 8'(p);
            send_byte(0, b0);
            send_byte(0, {4'(p), 4'hF});
        end
        settle();
        for (int k = 0; k < 15; k++) begin
            b0 = 8'h11 + 8'(k);
            check_write("frame_pixel", 0, n0 + k, k + 1, int'({b0, 4'(k + 1)}));
            checks++;
            if (log_fd[0][n0 + k] !== ((k == 14) ? 1 : 0)) begin
                errors++;
                $display("FAIL frame_done_addr%0d: frame_done %0d, required %0d", k + 1,
                         log_fd[0][n0 + k], (k == 14) ? 1 : 0);
            end
        end
        checks++;
        if (nfd[0] - f0 !== 1 || fcnt[0] !== 8'd1) begin
            errors++;
            $display("FAIL frame_count: frame_done pulses %0d frame_cnt %0d, required 1 and 1",
                     nfd[0] - f0, fcnt[0]);
        end
        check_write("frame_wrap", 0, n0 + 15, 0, 32'h200);
    endtask

    task automatic test_rx_gap();
        int n0;
        n0 = nwr[0];
        send_byte(0, 8'h5A);
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (nwr[0] !== n0) begin
            errors++;
            $display("FAIL rx_gap_hold: %0d writes during gap, required 0", nwr[0] - n0);
        end
        send_byte(0, 8'h3C);
        settle();
        check_write("rx_gap_pixel", 0, n0, 1, 32'h5A3);
    endtask

    task automatic test_resync();
        int n0;
        n0 = nwr[0];
        send_byte(0, 8'h77);
        resync[0] = 1'b1;
        @(negedge clk);
        resync[0] = 1'b0;
        send_byte(0, 8'hAB);
        send_byte(0, 8'hCD);
        settle();
        checks++;
        if (nwr[0] !== n0 + 1) begin
            errors++;
            $display("FAIL resync_count: %0d writes, required 1", nwr[0] - n0);
        end
        check_write("resync_pixel", 0, n0, 0, 32'hABC);
        checks++;
        if (fcnt[0] !== 8'd1) begin
            errors++;
            $display("FAIL resync_fcnt: frame_cnt %0d, required 1", fcnt[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = nwr[0];
        send_byte(0, 8'h01);
        send_byte(0, 8'h23);
        send_byte(0, 8'h45);
        send_byte(0, 8'h67);
        settle();
        check_write("b2b_first", 0, n0, 1, 32'h012);
        check_write("b2b_second", 0, n0 + 1, 2, 32'h456);
        checks++;
        if (log_cyc[0][n0 + 1] - log_cyc[0][n0] !== 3) begin
            errors++;
            $display("FAIL b2b_spacing: %0d cycles between writes, required 3",
                     log_cyc[0][n0 + 1] - log_cyc[0][n0]);
        end
    endtask

    task automatic test_one_shot();
        int p0, n0, f0;
        p0 = pops[1];
        resync[1] = 1'b1;
        @(negedge clk);
        resync[1]   = 1'b0;
        rx_data[1]  = 8'h11;
        rx_empty[1] = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (pops[1] !== p0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_idle: pops %0d busy %b, required 0 pops busy 0", pops[1] - p0, busy[1]);
        end
        @(negedge clk);
        rx_empty[1] = 1'b1;
        start[1]    = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        n0 = nwr[1];
        f0 = nfd[1];
        for (int p = 0; p < 16; p++) begin
            send_byte(1, 8'h20 + 8'(p));
            send_byte(1, 8'hC0);
        end
        settle();
        for (int k = 0; k < 16; k += 5) begin
            check_write("oneshot_pixel", 1, n0 + k, k, int'({8'h20 + 8'(k), 4'hC}));
        end
        check_write("oneshot_last", 1, n0 + 15, 15, 32'h2FC);
        checks++;
        if (nwr[1] - n0 !== 16 || nfd[1] - f0 !== 1 || fcnt[1] !== 8'd1) begin
            errors++;
            $display("FAIL oneshot_frame: writes %0d frame_done %0d cnt %0d, required 16 1 1",
                     nwr[1] - n0, nfd[1] - f0, fcnt[1]);
        end
        p0 = pops[1];
        rx_data[1]  = 8'h33;
        rx_empty[1] = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (pops[1] !== p0 || busy[1] !== 1'b0 || nwr[1] - n0 !== 16) begin
            errors++;
            $display("FAIL oneshot_done: pops %0d busy %b writes %0d, required 0 pops busy 0 writes 16",
                     pops[1] - p0, busy[1], nwr[1] - n0);
        end
        rx_empty[1] = 1'b1;
    endtask

    task automatic test_wide_narrow();
        send_byte(2, 8'h12);
        send_byte(2, 8'h34);
        send_byte(2, 8'h56);
        send_byte(3, 8'h9F);
        send_byte(3, 8'h3C);
        settle();
        check_write("wide24_pixel", 2, 0, 0, 32'h123456);
        check_write("narrow4_first", 3, 0, 0, 32'h9);
        check_write("narrow4_second", 3, 1, 1, 32'h3);
    endtask

    task automatic test_sync_header();
        int p0, n0;
        p0 = pops[0];
        n0 = nwr[0];
        send_byte(0, 8'h00);
        send_byte(0, 8'h11);
        send_byte(0, 8'hA5);
        send_byte(0, 8'hAB);
        send_byte(0, 8'hCD);
        settle();
        checks++;
        if (pops[0] - p0 !== 5 || nwr[0] - n0 !== 1) begin
            errors++;
            $display("FAIL header_counts: pops %0d writes %0d, required 5 and 1", pops[0] - p0, nwr[0] - n0);
        end
        check_write("header_pixel", 0, n0, 0, 32'hABC);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        settle();
        check_write("header_next_pixel", 0, n0 + 1, 1, 32'h123);
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = '0;
        rx_empty = 4'hF;
        start    = 4'h0;
        resync   = 4'h0;
        test_reset();
`ifdef UART_SYNC_HDR_EN
        test_sync_header();
`else
        test_first_pixel();
        test_frame();
        test_rx_gap();
        test_resync();
        test_back_to_back();
        test_one_shot();
        test_wide_narrow();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
